// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default line constants
// and the baud-tick divisor helper used by both RX and TX blocks.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam int DEF_CLK_FREQ  = 100_000_000;
    localparam int DEF_BAUD_RATE = 115_200;

    function automatic int calc_tick_div(input int clk_freq, input int baud_rate,
                                         input int oversample);
        return clk_freq / (baud_rate * oversample);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-cycle o_tick every TICK_DIV clocks,
// restartable through a synchronous clear so the phase can follow a line edge.
module uart_baud_tick #(
    parameter int TICK_DIV = 54
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    output logic o_tick
);

    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;

    assign o_tick = (r_cnt == LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with mid-bit oversampling, false-start rejection,
// framing/parity flags and a valid/ready output with overrun pulse.
// Optional parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx_param import uart_pkg::*; #(
    parameter int CLK_FREQ   = DEF_CLK_FREQ,
    parameter int BAUD_RATE  = DEF_BAUD_RATE,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_frame_err,
    output logic                 o_parity_err,
    output logic                 o_overrun
);

    localparam int            TICK_DIV  = calc_tick_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int            SW        = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] SMP_HALF  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SMP_LAST  = SW'(OVERSAMPLE - 1);
    localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic          PAR_ODD   = (PARITY_ODD != 0);
`ifdef UART_RX_PARITY_EN
    localparam logic          PAR_EN    = 1'b1;
`else
    localparam logic          PAR_EN    = 1'b0;
`endif

    uart_state_t          r_state, w_state_nxt;
    logic                 r_sync1, r_sync2, r_rx_prev;
    logic                 w_rx_s, w_fall, w_tick, w_tick_clr, w_mid, w_commit;
    logic [SW-1:0]        r_smp;
    logic [2:0]           r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_ferr, r_perr;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid, r_frame_err, r_parity_err, r_overrun;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= i_rx;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    assign w_rx_s     = r_sync2;
    assign w_fall     = r_rx_prev & ~r_sync2;
    assign w_tick_clr = (r_state == ST_IDLE);

    uart_baud_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (w_tick_clr),
        .o_tick (w_tick)
    );

    // The start bit is sampled half a bit in; every later sample is a full bit apart.
    assign w_mid = w_tick && (r_smp == ((r_state == ST_START) ? SMP_HALF : SMP_LAST));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        unique case (r_state)
            ST_IDLE:   if (w_fall) w_state_nxt = ST_START;
            ST_START:  if (w_mid) w_state_nxt = w_rx_s ? ST_IDLE : ST_DATA;
            ST_DATA:   if (w_mid && (r_bit == BIT_LAST)) w_state_nxt = PAR_EN ? ST_PARITY : ST_STOP;
            ST_PARITY: if (w_mid) w_state_nxt = ST_STOP;
            ST_STOP: begin
                if (w_mid && (r_bit == STOP_LAST)) begin
                    w_state_nxt = ST_IDLE;
                    w_commit    = 1'b1;
                end
            end
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || (r_state == ST_IDLE)) begin
            r_smp <= '0;
            r_bit <= '0;
        end else if (w_mid) begin
            r_smp <= '0;
            if (r_state == ST_DATA) begin
                r_bit <= (r_bit == BIT_LAST) ? 3'd0 : r_bit + 3'd1;
            end else if (r_state == ST_STOP) begin
                r_bit <= r_bit + 3'd1;
            end
        end else if (w_tick) begin
            r_smp <= r_smp + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_mid && (r_state == ST_DATA)) begin
            r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || (r_state == ST_IDLE)) begin
            r_ferr <= 1'b0;
            r_perr <= 1'b0;
        end else if (w_mid) begin
            if ((r_state == ST_STOP) && !w_rx_s) r_ferr <= 1'b1;
            if (r_state == ST_PARITY) r_perr <= (^r_shift) ^ w_rx_s ^ PAR_ODD;
        end
    end

    // A commit while the previous frame is still unaccepted drops the new frame.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (r_valid && i_ready) r_valid <= 1'b0;
            if (w_commit) begin
                if (!r_valid || i_ready) begin
                    r_data       <= r_shift;
                    r_frame_err  <= r_ferr | ~w_rx_s;
                    r_parity_err <= PAR_EN & r_perr;
                    r_valid      <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

    assign o_data       = r_data;
    assign o_valid      = r_valid;
    assign o_frame_err  = r_frame_err;
    assign o_parity_err = r_parity_err;
    assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: frames are driven bit by bit on i_rx and the
// expected bytes/flags are queued, then checked when the receiver hands them over.
module tb_uart_rx_param;

    localparam int   CLK_FREQ = 100_000_000;
    localparam int   BAUD     = 1_000_000;
    localparam int   OS       = 16;
    localparam int   TDIV     = CLK_FREQ / (BAUD * OS);
    localparam int   BIT      = TDIV * OS;
    localparam logic TB_ODD   = 1'b0;
`ifdef UART_RX_PARITY_EN
    localparam logic PAR_EN   = 1'b1;
`else
    localparam logic PAR_EN   = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] o_data;
    logic       o_valid, o_frame_err, o_parity_err, o_overrun;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_total = 0;
    int   n_pass = 0;
    int   n_acc = 0;
    int   n_ovr = 0;
    int   base_acc, base_ovr;

    always #5 clk = ~clk;

    uart_rx_param #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD),
        .OVERSAMPLE (OS),
        .DATA_BITS  (8),
        .STOP_BITS  (1),
        .PARITY_ODD (0)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_rx         (rx),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .i_ready      (ready),
        .o_frame_err  (o_frame_err),
        .o_parity_err (o_parity_err),
        .o_overrun    (o_overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v, input int n);
        rx = v;
        wait_clk(n);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_v);
        drive_bit(1'b0, BIT);
        for (int i = 0; i < 8; i++) drive_bit(d[i], BIT);
        if (PAR_EN) drive_bit(par_v, BIT);
        drive_bit(stop_v, BIT);
    endtask

    task automatic expect_frame(input logic [7:0] d, input logic stop_v, input logic par_v);
        exp_t e;
        e.data = d;
        e.ferr = ~stop_v;
        e.perr = PAR_EN & ((^d) ^ par_v ^ TB_ODD);
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst && o_overrun) n_ovr++;
        if (!rst && o_valid && ready) begin
            n_acc++;
            chk("sb_entry", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("rx_data", 32'(o_data), 32'(mon_e.data));
                chk("rx_frame_err", 32'(o_frame_err), 32'(mon_e.ferr));
                chk("rx_parity_err", 32'(o_parity_err), 32'(mon_e.perr));
            end
        end
    end

    initial begin
        rst = 1'b1;
        rx = 1'b1;
        ready = 1'b1;
        wait_clk(3);
        chk("reset_valid", 32'(o_valid), 0);
        chk("reset_data", 32'(o_data), 0);
        chk("reset_frame_err", 32'(o_frame_err), 0);
        chk("reset_parity_err", 32'(o_parity_err), 0);
        chk("reset_overrun", 32'(o_overrun), 0);
        rst = 1'b0;
        wait_clk(20);

        // clean frame, consumer always ready
        base_acc = n_acc;
        expect_frame(8'hA5, 1'b1, ^8'hA5);
        send_frame(8'hA5, 1'b1, ^8'hA5);
        drive_bit(1'b1, BIT);
        chk("a5_accepts", n_acc - base_acc, 1);
        chk("a5_valid_low", 32'(o_valid), 0);
        chk("a5_no_overrun", n_ovr, 0);

        // short low glitch must be rejected as a false start
        base_acc = n_acc;
        drive_bit(1'b0, BIT / 4);
        drive_bit(1'b1, 2 * BIT);
        chk("glitch_accepts", n_acc - base_acc, 0);
        chk("glitch_valid", 32'(o_valid), 0);
        expect_frame(8'h3C, 1'b1, ^8'h3C);
        send_frame(8'h3C, 1'b1, ^8'h3C);
        drive_bit(1'b1, BIT);
        chk("post_glitch_accepts", n_acc - base_acc, 1);

        // stop bit low, line stays low: one frame with framing error only
        base_acc = n_acc;
        expect_frame(8'h3C, 1'b0, ^8'h3C);
        send_frame(8'h3C, 1'b0, ^8'h3C);
        wait_clk(5 * BIT);
        chk("ferr_accepts", n_acc - base_acc, 1);
        drive_bit(1'b1, 2 * BIT);
        chk("ferr_no_extra", n_acc - base_acc, 1);

        // consumer stalled across two frames: second is dropped with an overrun pulse
        ready = 1'b0;
        base_acc = n_acc;
        base_ovr = n_ovr;
        expect_frame(8'h11, 1'b1, ^8'h11);
        send_frame(8'h11, 1'b1, ^8'h11);
        send_frame(8'h22, 1'b1, ^8'h22);
        drive_bit(1'b1, BIT);
        chk("ovr_pulses", n_ovr - base_ovr, 1);
        chk("ovr_valid_held", 32'(o_valid), 1);
        chk("ovr_data_held", 32'(o_data), 'h11);
        chk("ovr_no_accept", n_acc - base_acc, 0);
        ready = 1'b1;
        wait_clk(1);
        ready = 1'b0;
        chk("ovr_one_accept", n_acc - base_acc, 1);
        chk("ovr_valid_drop", 32'(o_valid), 0);
        ready = 1'b1;

`ifdef UART_RX_PARITY_EN
        base_acc = n_acc;
        expect_frame(8'h07, 1'b1, 1'b1);
        send_frame(8'h07, 1'b1, 1'b1);
        expect_frame(8'h07, 1'b1, 1'b0);
        send_frame(8'h07, 1'b1, 1'b0);
        drive_bit(1'b1, BIT);
        chk("parity_accepts", n_acc - base_acc, 2);
`endif

        // hold a flagged frame, then reset in the middle of data bit 3 of 0xFF
        ready = 1'b0;
        send_frame(8'h81, 1'b0, ^8'h81);
        drive_bit(1'b1, BIT);
        chk("pre_rst_valid", 32'(o_valid), 1);
        chk("pre_rst_frame_err", 32'(o_frame_err), 1);
        base_acc = n_acc;
        drive_bit(1'b0, BIT);
        for (int i = 0; i < 3; i++) drive_bit(1'b1, BIT);
        drive_bit(1'b1, BIT / 2);
        rst = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_data", 32'(o_data), 0);
        chk("rst_frame_err", 32'(o_frame_err), 0);
        chk("rst_parity_err", 32'(o_parity_err), 0);
        chk("rst_overrun", 32'(o_overrun), 0);
        ready = 1'b1;
        drive_bit(1'b1, 7 * BIT);
        chk("rst_frame_dropped", n_acc - base_acc, 0);
        expect_frame(8'h5A, 1'b1, ^8'h5A);
        send_frame(8'h5A, 1'b1, ^8'h5A);
        drive_bit(1'b1, BIT);
        chk("post_rst_accepts", n_acc - base_acc, 1);

        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
